// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin resource arbiter.
// Holds the FSM state enum and the circular first-set search used for arbitration.
package rr_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } rr_arb_state_e;

   // Widest requester vector the search helper handles; index carries one spare bit.
   localparam int unsigned RR_MAX_REQ = 64;
   localparam int unsigned RR_IDX_W   = 7;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   function automatic rr_pick_t rr_first_set(
      input logic [RR_MAX_REQ-1:0] vec,
      input int unsigned           start,
      input int unsigned           n
   );
      rr_pick_t    pick;
      int unsigned k;
      pick = '0;
      for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
         if (i < n) begin
            k = start + i;
            if (k >= n) k = k - n;
            if (!pick.found && vec[k[5:0]]) begin
               pick.found = 1'b1;
               pick.idx   = RR_IDX_W'(k);
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_resource_arbiter_dec.sv
// Binary-to-one-hot decoder with a valid gate.
// Output is all zero when a_valid_i is low, otherwise exactly the bit at a_i.
module rr_resource_arbiter_dec #(
   parameter int NUM_WIRE = 4
) (
   input  logic [$clog2(NUM_WIRE)-1:0] a_i,
   input  logic                        a_valid_i,
   output logic [NUM_WIRE-1:0]         y_o
);

   localparam int AW = $clog2(NUM_WIRE);

   always_comb begin
      y_o = '0;
      for (int i = 0; i < NUM_WIRE; i++) begin
         y_o[i] = a_valid_i && (a_i == AW'(i));
      end
   end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter sharing one resource among NUM_REQ requesters.
// A grant is held until release, withdrawal or (optionally) the hold-time limit.
module rr_resource_arbiter
   import rr_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int MAX_HOLD = 0
) (
   input  logic                       clk_i,
   input  logic                       arst_ni,
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic                       release_i,
   output logic [NUM_REQ-1:0]         gnt_o,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
   output logic                       gnt_valid_o,
   output logic                       timeout_o
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   // Handshake: req_i is a level held by each requester for as long as it wants
   // the resource; the holder ends its grant either by pulsing release_i for one
   // cycle or by dropping its req_i bit. No other requester can disturb a grant.

   rr_arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [CNT_W-1:0]     hold_q, hold_d;
   logic                 timeout_q, timeout_d;

   logic                  rel_end, wd_end, to_end, grant_end;
   logic [IDX_W-1:0]      ptr_wrap;
   logic [RR_MAX_REQ-1:0] search_vec;
   int unsigned           search_start;
   rr_pick_t              pick;
   logic                  pick_ok;

   assign rel_end   = release_i;
   assign wd_end    = ~req_i[idx_q];
   assign to_end    = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
   assign grant_end = rel_end | wd_end | to_end;
   assign ptr_wrap  = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

   // The ending holder is masked out for the same-cycle re-arbitration only.
   always_comb begin
      search_vec                = '0;
      search_vec[NUM_REQ-1:0]   = req_i;
      search_start              = 32'(ptr_q);
      if (state_q == GRANT) begin
         search_vec[idx_q] = 1'b0;
         search_start      = 32'(ptr_wrap);
      end
      pick    = rr_first_set(search_vec, search_start, NUM_REQ);
      pick_ok = pick.found && (pick.idx < RR_IDX_W'(NUM_REQ));
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         idx_q     <= '0;
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_ok) begin
               idx_d   = pick.idx[IDX_W-1:0];
               hold_d  = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (grant_end) begin
               ptr_d     = ptr_wrap;
               hold_d    = '0;
               timeout_d = to_end & ~rel_end & ~wd_end;
               if (pick_ok) begin
                  idx_d = pick.idx[IDX_W-1:0];
               end else begin
                  state_d = IDLE;
               end
            end else if (hold_q != '1) begin
               hold_d = hold_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_valid_o = (state_q == GRANT);
      gnt_idx_o   = idx_q;
      timeout_o   = timeout_q;
   end

   rr_resource_arbiter_dec #(
      .NUM_WIRE (NUM_REQ)
   ) u_dec (
      .a_i       (idx_q),
      .a_valid_i (state_q == GRANT),
      .y_o       (gnt_o)
   );

endmodule
